// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider: operands and start strobe in,
// FSM status and results out.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 5
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  state, count, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output state, count, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: WAIT/SETUP/COMPUTE/DONE FSM retiring one
// quotient bit per clock; results are held until the next operation completes.
module seq_divider #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {
        StWait    = 2'd0,
        StSetup   = 2'd1,
        StCompute = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CountMax  = CW'(WIDTH);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] diff;

    // Shift {R,Q} left by one and trial-subtract the divisor; MSB of diff is the borrow.
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign diff    = r_shift - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            StWait: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                r_d     = '0;
                count_d = '0;
                if (d_q == '0) begin
                    quot_d  = '1;
                    rem_d   = q_q;
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    dbz_d   = 1'b0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (!diff[WIDTH]) begin
                    r_d = diff;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_shift;
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (count_q != CountMax) begin
                    count_d = count_q + CW'(1);
                end
                if (count_q == LastCount) begin
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StWait;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            count_q <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.count       = count_q;
    assign bus.busy        = (state_q == StSetup) || (state_q == StCompute);
    assign bus.done        = (state_q == StDone);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes model results per accepted start,
// a negedge monitor checks busy/done timing every cycle and results on each done pulse.
module tb_seq_divider;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    seq_divider_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    seq_divider #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    bit          op_active = 1'b0;
    int unsigned op_acc    = 0;
    bit          op_dz     = 1'b0;

    function automatic void check(string name, longint unsigned act, longint unsigned req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: plain integer division, with the all-ones/dividend convention for /0.
    function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 16'd1;
            3:       return 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: timing expectations derived from the accepting cycle of the current op.
    always @(negedge clk) begin
        if (reset_n) begin
            int unsigned op_end;
            bit exp_busy, exp_done;
            op_end   = op_acc + (op_dz ? 1 : WIDTH + 1);
            exp_busy = op_active && (cyc >= op_acc) && (cyc < op_end);
            exp_done = op_active && (cyc == op_end);
            check("busy", 64'(bus.busy), 64'(exp_busy));
            check("done", 64'(bus.done), 64'(exp_done));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", 64'(bus.quotient), 64'(e.q));
                    check("remainder", 64'(bus.remainder), 64'(e.r));
                    check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
                    if (e.b != 0) begin
                        check("invariant", 64'(bus.quotient) * 64'(e.b) + 64'(bus.remainder),
                              64'(e.a));
                        check("rem_lt_div", 64'(bus.remainder < e.b), 64'(1));
                    end
                end
            end
        end
    end

    // Waits at negedges for WAIT, then presents one request; returns 1ns after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int k = 0;
        @(negedge clk);
        while (bus.state != 2'd0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            check("wait_idle_timeout", 64'(bus.state), 64'(0));
            return;
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b));
        op_acc    = cyc + 1;
        op_dz     = (b == 0);
        op_active = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
    endtask

    task automatic wait_state(input logic [1:0] st, input int cnt);
        int k = 0;
        @(negedge clk);
        while (!(bus.state == st && (cnt < 0 || int'(bus.count) == cnt)) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check("wait_state_timeout", 64'(bus.state), 64'(st));
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 64'(bus.state), 64'(0));
        check({tag, "_count"}, 64'(bus.count), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_done"}, 64'(bus.done), 64'(0));
        check({tag, "_quot"}, 64'(bus.quotient), 64'(0));
        check({tag, "_rem"}, 64'(bus.remainder), 64'(0));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // 100/7 with explicit state/count sequence.
        issue(16'd100, 16'd7);
        for (int i = 0; i < 19; i++) begin
            logic [1:0] es;
            @(negedge clk);
            es = (i == 0) ? 2'd1 : (i <= 16) ? 2'd2 : (i == 17) ? 2'd3 : 2'd0;
            check($sformatf("seq_state_%0d", i), 64'(bus.state), 64'(es));
            if (i == 17) check("count_at_done", 64'(bus.count), 64'(WIDTH));
        end

        issue(16'hFFFF, 16'd1);
        issue(16'd5, 16'd9);
        issue(16'hFFFF, 16'hFFFF);
        issue(16'd1234, 16'd0);
        issue(16'd1234, 16'd2);
        issue(16'd0, 16'd77);
        drain();

        // Operand and start changes while busy or in DONE must be ignored.
        issue(16'd1000, 16'd3);
        wait_state(2'd2, 5);
        bus.dividend = 16'd9;
        bus.divisor  = 16'd9;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_state(2'd3, -1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after_done_start", 64'(bus.state), 64'(0));
        end
        drain();

        // Asynchronous reset mid-COMPUTE.
        issue(16'd50000, 16'd123);
        wait_state(2'd2, 8);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        op_active = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(16'd50000, 16'd123);
        drain();

        for (int i = 0; i < 1000; i++) begin
            issue(pick(), pick());
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's sequential multiplier, built as the same WAIT/SETUP/COMPUTE/DONE FSM.
- Retires one quotient bit per clock.
- Sits beside the multiplier in the ALU datapath.
- Accepts a start strobe, returns quotient and remainder with a done pulse, and holds results until the next operation.

Parameters:
- WIDTH, 16, operand/result width in bits; WIDTH >= 2.
- CW, 5, iteration counter width; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in WAIT.
- dividend  input  WIDTH  unsigned numerator; captured on the accepting edge.
- divisor  input  WIDTH  unsigned denominator; captured on the accepting edge.
- state  output  2  FSM state: WAIT=0, SETUP=1, COMPUTE=2, DONE=3.
- count  output  CW  iterations completed in the current operation.
- busy  output  1  high in SETUP and COMPUTE; low in WAIT and DONE.
- done  output  1  one-cycle pulse, high only while state==DONE.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  set when the captured divisor was 0.

Behaviour:
- Reset (reset_n low, asynchronous): state=WAIT, count=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. All internal registers are cleared.
- Reset mid-operation: abort immediately. Nothing is preserved. The first start after reset is accepted normally.

WAIT:
- On a clk edge with start=1: capture dividend into the Q shift register and divisor into register D, then go to SETUP.
- With start=0: stay in WAIT.
- quotient, remainder and div_by_zero keep their last values.

SETUP (1 cycle):
- Clear the 17-bit (WIDTH+1) partial remainder R to 0 and clear count to 0.
- If D==0: go to DONE, with quotient=all ones, remainder=captured dividend, div_by_zero=1.
- Otherwise: div_by_zero=0, go to COMPUTE.

COMPUTE (exactly WIDTH cycles):
- Each edge:
  - Form {R,Q} shifted left by 1.
  - Compute T = R_shifted − {0,D} at WIDTH+1 bits.
  - If T's MSB is 0: R=T and Q[0]=1. Otherwise keep R_shifted and set Q[0]=0.
  - Increment count.
- On the edge where count reaches WIDTH: load quotient=Q (final) and remainder=R[WIDTH-1:0], then go to DONE.
- count saturates at WIDTH and never wraps.

DONE (1 cycle):
- done=1. Next edge goes to WAIT unconditionally.
- start is ignored in DONE.

Timing and rules:
- Latency: on the accepting edge E, done is high during the cycle following edge E+WIDTH+1, i.e. edge E+17 for WIDTH=16. For divide-by-zero the next state is already DONE at edge E+1, and done is high after edge E+1.
- Throughput: a new start is accepted no earlier than the edge after DONE, giving WIDTH+3 cycles per operation.
- start held high continuously gives back-to-back operations, each capturing operands anew in WAIT.
- start, dividend and divisor changes while busy or in DONE are ignored. Captured operands are immune to input changes.
- Invariant for nonzero divisor: dividend == quotient*divisor + remainder, with remainder < divisor.
- Dividend < divisor gives quotient=0, remainder=dividend.
- Dividend==0 gives quotient=0, remainder=0 (normal path, full latency).
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then dividend=100, divisor=7, start pulsed 1 cycle:
  - state sequence is 1, then 2 for 16 cycles, then 3, then 0.
  - done is a single-cycle pulse 17 cycles after the accepting edge.
  - quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFF, divisor=1 gives quotient=0xFFFF, remainder=0. Then dividend=5, divisor=9 gives quotient=0, remainder=5. Then dividend=0xFFFF, divisor=0xFFFF gives quotient=1, remainder=0.
- dividend=1234, divisor=0:
  - done goes high 1 cycle after the accepting edge.
  - quotient=0xFFFF, remainder=1234, div_by_zero=1.
  - A following 1234/2 gives quotient=617, remainder=0, div_by_zero=0.
- Start 1000/3, then in COMPUTE cycle 5 change the operands to 9/9 and pulse start:
  - result is quotient=333, remainder=1.
  - only one done pulse occurs.
  - start sampled in DONE launches nothing.
- Start 50000/123, then assert reset_n low asynchronously mid-cycle in COMPUTE with count=8:
  - all outputs are 0 immediately.
  - after release, 50000/123 gives quotient=406, remainder=62.
- Random regression of 1000 operand pairs, including 0 and all-ones corners:
  - for divisor≠0, check quotient*divisor+remainder==dividend and remainder<divisor.
  - check busy and done timing on every operation.
